mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_iter_core.sv | 33 +++
 rtl/mult_div_unit.sv | 115 +++++++++++
 tb/tb_mult_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared state encoding, iteration constants and magnitude helper
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one unsigned shift-add (multiply) or restoring shift-subtract (divide) step
module mdu_iter_core (
  input  logic        is_div,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] b,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
    shifted = {hi, lo[31]};
    ge      = (shifted >= {1'b0, b});
    // when ge holds the difference is below 2^32, so 32 bits suffice
    diff    = shifted[31:0] - b;
    hi_next = '0;
    lo_next = '0;
    if (is_div) begin
      hi_next = ge ? diff : shifted[31:0];
      lo_next = {lo[30:0], ge};
    end else begin
      hi_next = sum[32:1];
      lo_next = {sum[0], lo[31:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed 32x32 multiply / 32/32 divide with hi/lo results
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result,
  output logic        mult_div_done,
  output logic        busy,
  output logic        div_by_zero
);

  import mdu_pkg::*;

  mdu_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_acc, lo_acc, b_mag;
  logic             sign_a, sign_b, is_div;
  logic [31:0]      hi_step, lo_step;
  logic [63:0]      prod;
  logic [31:0]      fix_hi, fix_lo;

  mdu_iter_core u_core (
    .is_div  (state == S_DIV),
    .hi      (hi_acc),
    .lo      (lo_acc),
    .b       (b_mag),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    busy          = (state != S_IDLE);
    mult_div_done = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (mult_start)     next_state = S_MULT;
        else if (div_start) next_state = S_DIV;
      end
      S_MULT, S_DIV: if (cnt == '0) next_state = S_FIX;
      S_FIX:         next_state = S_DONE;
      S_DONE:        next_state = S_IDLE;
      default:       next_state = S_IDLE;
    endcase
  end

  // Sign correction: quotient/product follow sign_a^sign_b, remainder follows the dividend
  always_comb begin
    prod   = {hi_acc, lo_acc};
    fix_hi = '0;
    fix_lo = '0;
    if (is_div) begin
      fix_hi = sign_a ? (~hi_acc + 32'd1) : hi_acc;
      fix_lo = (sign_a ^ sign_b) ? (~lo_acc + 32'd1) : lo_acc;
      if (b_mag == '0) fix_lo = '1;
    end else begin
      if (sign_a ^ sign_b) prod = ~prod + 64'd1;
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt         <= '0;
      hi_acc      <= '0;
      lo_acc      <= '0;
      b_mag       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      is_div      <= 1'b0;
      hi_result   <= '0;
      lo_result   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mult_start || div_start) begin
            sign_a      <= src_a[31];
            sign_b      <= src_b[31];
            hi_acc      <= '0;
            lo_acc      <= mag32(src_a);
            b_mag       <= mag32(src_b);
            is_div      <= !mult_start;
            div_by_zero <= 1'b0;
            cnt         <= CNT_W'(ITER - 1);
          end
        end
        S_MULT, S_DIV: begin
          hi_acc <= hi_step;
          lo_acc <= lo_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (is_div && b_mag == '0) div_by_zero <= 1'b1;
        end
        S_FIX: begin
          hi_result <= fix_hi;
          lo_result <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - vector table, corner sequences and randomized checks against an arithmetic model
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] hi_result, lo_result;
  logic        mult_div_done, busy, div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mult_div_unit #(.ITER(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .mult_start    (mult_start),
    .div_start     (div_start),
    .src_a         (src_a),
    .src_b         (src_b),
    .hi_result     (hi_result),
    .lo_result     (lo_result),
    .mult_div_done (mult_div_done),
    .busy          (busy),
    .div_by_zero   (div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          exp_dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero
  task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output bit dbz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    if (!is_div) begin
      p = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dbz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  // Launches one operation, samples every cycle at the falling edge, returns what it saw
  task automatic run_op(input bit do_mult, input bit do_div, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_cycle, input bit exp_dbz,
                        output logic [31:0] hi, output logic [31:0] lo, output bit dbz,
                        output int done_cyc, output bit busy_ok, output bit stable_ok,
                        output bit once_ok);
    done_cyc = -1;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    once_ok = 1'b0;
    hi = 'x; lo = 'x; dbz = 1'b0;
    @(negedge CLK);
    mult_start = do_mult;
    div_start = do_div;
    src_a = a;
    src_b = b;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      mult_start = 1'b0;
      div_start = (k == pulse_cycle);
      if (k == 1) begin
        src_a = $urandom;
        src_b = $urandom;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k <= 33 && (hi_result !== last_hi || lo_result !== last_lo)) stable_ok = 1'b0;
      if (k <= 32 && div_by_zero !== 1'b0) stable_ok = 1'b0;
      if (k == 33 && div_by_zero !== exp_dbz) stable_ok = 1'b0;
      if (mult_div_done === 1'b1) begin
        done_cyc = k;
        hi = hi_result;
        lo = lo_result;
        dbz = div_by_zero;
        break;
      end
    end
    div_start = 1'b0;
    @(negedge CLK);
    once_ok = (mult_div_done === 1'b0) && (busy === 1'b0) &&
              (hi_result === hi) && (lo_result === lo);
  endtask

  task automatic do_op(input string name, input bit do_mult, input bit do_div,
                       input logic [31:0] a, input logic [31:0] b, input int pulse_cycle,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit exp_dbz);
    logic [31:0] hi, lo;
    bit dbz, busy_ok, stable_ok, once_ok;
    int dc;
    run_op(do_mult, do_div, a, b, pulse_cycle, exp_dbz, hi, lo, dbz, dc, busy_ok, stable_ok, once_ok);
    check({name, ".done_cycle"}, 64'(dc), 64'd34);
    check({name, ".hi"}, 64'(hi), 64'(exp_hi));
    check({name, ".lo"}, 64'(lo), 64'(exp_lo));
    check({name, ".dbz"}, 64'(dbz), 64'(exp_dbz));
    check({name, ".busy"}, 64'(busy_ok), 64'd1);
    check({name, ".stable"}, 64'(stable_ok), 64'd1);
    check({name, ".done_once"}, 64'(once_ok), 64'd1);
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] a, b, ehi, elo;
    bit edbz, md, ok;

    vecs = '{
      '{1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0},
      '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0},
      '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0},
      '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
      '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0},
      '{1'b1, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1},
      '{1'b0, 32'd3,         32'd4,         32'h0000_0000, 32'h0000_000C, 1'b0},
      '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
      '{1'b1, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000, 1'b0},
      '{1'b1, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1},
      '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0}
    };

    // reset state
    repeat (2) @(negedge CLK);
    check("reset.hi", 64'(hi_result), 64'd0);
    check("reset.lo", 64'(lo_result), 64'd0);
    check("reset.flags", {61'd0, mult_div_done, busy, div_by_zero}, 64'd0);
    RST = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), !vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, 0,
            vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);

    // both starts together, plus a stray div_start mid-operation
    do_op("both_start", 1'b1, 1'b1, 32'd6, 32'd3, 10, 32'd0, 32'd18, 1'b0);

    // reset at cycle 10 of a divide
    @(negedge CLK);
    div_start = 1'b1; src_a = 32'd1000; src_b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      div_start = 1'b0;
    end
    RST = 1'b0;
    #1;
    check("rst_mid.hi", 64'(hi_result), 64'd0);
    check("rst_mid.lo", 64'(lo_result), 64'd0);
    check("rst_mid.flags", {61'd0, mult_div_done, busy, div_by_zero}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (mult_div_done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("rst_mid.no_done", 64'(ok), 64'd1);
    last_hi = '0;
    last_lo = '0;
    do_op("after_rst", 1'b0, 1'b1, 32'd100, 32'd7, 0, 32'd2, 32'd14, 1'b0);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      md = $urandom_range(0, 1);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      model(md, a, b, ehi, elo, edbz);
      do_op($sformatf("rnd%0d", i), !md, md, a, b, 0, ehi, elo, edbz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
